// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI4-lite load/store master.
package axi_lite_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

endpackage

// File: rtl/axi_lite_lsu_master.sv
// AXI4-lite initiator turning single-outstanding core loads/stores into AXI4-lite transactions.
// Optional watchdog with sticky timeout_flag output: define AXI_LITE_LSU_TIMEOUT_EN.
module axi_lite_lsu_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
`ifdef AXI_LITE_LSU_TIMEOUT_EN
  output logic              timeout_flag,
`endif
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  state_t            state_reg, state_next;
  logic              req_ready_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg, data_reg;
  logic [3:0]        strb_reg;
  logic              err_reg, aw_done_reg, w_done_reg, ar_done_reg;
  logic              accept, rd_done, wr_done, timeout_hit;
  logic              unused_bits;

  assign unused_bits = ^{req_wstrb[7:4], rresp[0], bresp[0], (TIMEOUT_CYCLES != 0)};

  // rready/bready are held for the whole RD/WR state, so the responder's valid alone completes it.
  assign accept  = (state_reg == IDLE) && req_ready_reg && req_valid;
  assign rd_done = (state_reg == RD) && rvalid;
  assign wr_done = (state_reg == WR) && bvalid;

`ifdef AXI_LITE_LSU_TIMEOUT_EN
  logic [31:0] count_reg;
  logic        timeout_flag_reg;

  assign timeout_hit = ((state_reg == RD) || (state_reg == WR)) && !rd_done && !wr_done &&
                       (count_reg == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg        <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      if (accept)
        count_reg <= '0;
      else if ((state_reg == RD) || (state_reg == WR))
        count_reg <= count_reg + 32'd1;
      if (timeout_hit)
        timeout_flag_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_we ? WR : RD;
      RD:      if (rd_done || timeout_hit) state_next = RESP;
      WR:      if (wr_done || timeout_hit) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, per-channel handshake flags and captured response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      strb_reg      <= '0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      ar_done_reg   <= 1'b0;
    end else begin
      req_ready_reg <= (state_next == IDLE);
      if (accept) begin
        addr_reg    <= req_addr;
        wdata_reg   <= req_wdata;
        strb_reg    <= req_wstrb[3:0];
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
        ar_done_reg <= 1'b0;
      end
      if (arvalid && arready) ar_done_reg <= 1'b1;
      if (awvalid && awready) aw_done_reg <= 1'b1;
      if (wvalid && wready)   w_done_reg  <= 1'b1;
      if (rd_done) begin
        data_reg <= rdata;
        err_reg  <= rresp[1];
      end else if (wr_done) begin
        data_reg <= '0;
        err_reg  <= bresp[1];
      end else if (timeout_hit) begin
        data_reg <= '0;
        err_reg  <= RESP_SLVERR[1];
      end
    end
  end

  always_comb begin
    req_ready  = req_ready_reg;
    arvalid    = (state_reg == RD) && !ar_done_reg;
    rready     = (state_reg == RD);
    awvalid    = (state_reg == WR) && !aw_done_reg;
    wvalid     = (state_reg == WR) && !w_done_reg;
    bready     = (state_reg == WR);
    araddr     = addr_reg;
    awaddr     = addr_reg;
    wdata      = wdata_reg;
    wstrb      = {4'h0, strb_reg};
    resp_valid = (state_reg == RESP);
    resp_rdata = resp_valid ? data_reg : '0;
    resp_err   = resp_valid && err_reg;
  end

endmodule
